// File: rtl/wb_merge_queue_pkg.sv
// Shared widths and the buffered writeback entry type for the writeback merge queue.
// Result and tag widths are fixed here so the buffer, lookup and port slices agree.
package wb_merge_queue_pkg;

  localparam int DATA_W = 16;
  localparam int TAG_W  = 5;

  localparam logic [TAG_W-1:0] TAG_NONE = '0;

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_merge_queue_tag_match.sv
// One forwarding lookup port: returns the youngest valid buffered entry whose tag matches.
module wb_tag_match
  import wb_merge_queue_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  wb_entry_t         entries [DEPTH],
  input  logic [PTR_W-1:0]  head,
  input  logic [CNT_W-1:0]  count,
  input  logic [TAG_W-1:0]  lk_tag,
  output logic              lk_hit,
  output logic [DATA_W-1:0] lk_data
);

  always_comb begin
    // NOTE: every output gets a default before the loop, so no path leaves it unassigned (no latch).
    lk_hit  = 1'b0;
    lk_data = '0;
    // Scan oldest to youngest; a later match overrides, so the youngest entry wins.
    for (int i = 0; i < DEPTH; i++) begin
      if (CNT_W'(i) < count && lk_tag != TAG_NONE &&
          entries[head + PTR_W'(i)].tag == lk_tag) begin
        lk_hit  = 1'b1;
        lk_data = entries[head + PTR_W'(i)].data;
      end
    end
  end

endmodule

// File: rtl/wb_merge_queue.sv
// Writeback merge queue: compacts up to LANES results per cycle into a circular buffer and
// retires them in program order through WR_PORTS register-file ports, with ID-side forwarding.
module wb_merge_queue
  import wb_merge_queue_pkg::*;
#(
  parameter int LANES    = 4,
  parameter int WR_PORTS = 2,
  parameter int DEPTH    = 8,
  parameter int LOOKUPS  = 9
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [LANES-1:0]             in_valid,
  input  logic [LANES*DATA_W-1:0]      in_data,
  input  logic [LANES*TAG_W-1:0]       in_tag,
  output logic                         stall,
  output logic [WR_PORTS-1:0]          wr_en,
  output logic [WR_PORTS*DATA_W-1:0]   wr_data,
  output logic [WR_PORTS*TAG_W-1:0]    wr_tag,
  input  logic [LOOKUPS*TAG_W-1:0]     lk_tag,
  output logic [LOOKUPS-1:0]           lk_hit,
  output logic [LOOKUPS*DATA_W-1:0]    lk_data
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0] head, tail;
  logic [CNT_W-1:0] count, count_next, push_cnt, pop_cnt;
  logic             stall_next;
  wb_entry_t        mem [DEPTH];

  logic [LANES-1:0] lane_push;
  logic [PTR_W-1:0] lane_off   [LANES];
  wb_entry_t        lane_entry [LANES];

  logic [WR_PORTS-1:0] present;
  wb_entry_t           port_entry [WR_PORTS];

  // Compaction: each accepted lane lands at tail plus the number of accepted lanes before it.
  always_comb begin
    push_cnt = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_entry[i] = '{tag: in_tag[i*TAG_W +: TAG_W], data: in_data[i*DATA_W +: DATA_W]};
      lane_push[i]  = !stall && in_valid[i] && lane_entry[i].tag != TAG_NONE;
      lane_off[i]   = push_cnt[PTR_W-1:0];
      push_cnt      = push_cnt + CNT_W'(lane_push[i]);
    end
  end

  // Presentation: the oldest min(count, WR_PORTS) entries go out; an older duplicate tag is
  // suppressed so the register file sees each destination once per cycle.
  always_comb begin
    pop_cnt = (count < CNT_W'(WR_PORTS)) ? count : CNT_W'(WR_PORTS);
    wr_en   = '0;
    wr_data = '0;
    wr_tag  = '0;
    for (int k = 0; k < WR_PORTS; k++) begin
      present[k]    = CNT_W'(k) < count;
      port_entry[k] = mem[head + PTR_W'(k)];
    end
    for (int k = 0; k < WR_PORTS; k++) begin
      wr_en[k] = present[k];
      for (int j = k + 1; j < WR_PORTS; j++) begin
        if (present[j] && port_entry[j].tag == port_entry[k].tag) wr_en[k] = 1'b0;
      end
      wr_data[k*DATA_W +: DATA_W] = port_entry[k].data;
      wr_tag[k*TAG_W +: TAG_W]    = port_entry[k].tag;
    end
  end

  assign count_next = count - pop_cnt + push_cnt;
  assign stall_next = (CNT_W'(DEPTH) - count_next) < CNT_W'(LANES);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      stall <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      head  <= head + PTR_W'(pop_cnt);
      tail  <= tail + PTR_W'(push_cnt);
      count <= count_next;
      stall <= stall_next;
    end
  end

  // NOTE: storage is deliberately not reset; count alone decides which entries are valid.
  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (lane_push[i]) mem[tail + lane_off[i]] <= lane_entry[i];
    end
  end

  for (genvar g = 0; g < LOOKUPS; g++) begin : g_lookup
    wb_tag_match #(.DEPTH(DEPTH)) u_match (
      .entries (mem),
      .head    (head),
      .count   (count),
      .lk_tag  (lk_tag[g*TAG_W +: TAG_W]),
      .lk_hit  (lk_hit[g]),
      .lk_data (lk_data[g*DATA_W +: DATA_W])
    );
  end

  // The stall threshold keeps a full-width push from ever filling the buffer.
  a_never_full: assert property (@(posedge clk) disable iff (!rst_n) count != CNT_W'(DEPTH));

endmodule

// File: tb/tb_wb_merge_queue.sv
// Self-checking bench for wb_merge_queue: queue-based reference model plus directed literal checks.
module tb_wb_merge_queue;

  logic          clk;
  logic          rst_n;
  logic [3:0]    in_valid;
  logic [63:0]   in_data;
  logic [19:0]   in_tag;
  logic          stall;
  logic [1:0]    wr_en;
  logic [31:0]   wr_data;
  logic [9:0]    wr_tag;
  logic [44:0]   lk_tag;
  logic [8:0]    lk_hit;
  logic [143:0]  lk_data;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [4:0]  tag;
    logic [15:0] data;
  } ent_t;

  ent_t q[$];
  logic m_stall;

  wb_merge_queue dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_tag   (in_tag),
    .stall    (stall),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .wr_tag   (wr_tag),
    .lk_tag   (lk_tag),
    .lk_hit   (lk_hit),
    .lk_data  (lk_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an in-order list of buffered results; retire up to two per cycle.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_stall <= 1'b0;
    end else begin
      int n;
      n = (q.size() < 2) ? q.size() : 2;
      for (int i = 0; i < n; i++) void'(q.pop_front());
      if (!m_stall) begin
        for (int i = 0; i < 4; i++) begin
          if (in_valid[i] && in_tag[i*5 +: 5] != 5'd0)
            q.push_back('{tag: in_tag[i*5 +: 5], data: in_data[i*16 +: 16]});
        end
      end
      m_stall <= (8 - q.size()) < 4;
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    int          n;
    logic [1:0]  exp_en;
    logic [4:0]  t;
    logic        e_hit;
    logic [15:0] e_data;
    n = (q.size() < 2) ? q.size() : 2;
    for (int k = 0; k < 2; k++) begin
      exp_en[k] = (k < n);
      for (int j = k + 1; j < n; j++)
        if (q[j].tag == q[k].tag) exp_en[k] = 1'b0;
    end
    check("model_stall", stall, m_stall);
    check("model_wr_en", wr_en, exp_en);
    for (int k = 0; k < 2; k++) begin
      if (exp_en[k]) begin
        check($sformatf("model_wr_tag%0d", k), wr_tag[k*5 +: 5], q[k].tag);
        check($sformatf("model_wr_data%0d", k), wr_data[k*16 +: 16], q[k].data);
      end
    end
    for (int p = 0; p < 9; p++) begin
      t      = lk_tag[p*5 +: 5];
      e_hit  = 1'b0;
      e_data = 16'h0;
      if (t != 5'd0) begin
        for (int i = q.size() - 1; i >= 0 && !e_hit; i--) begin
          if (q[i].tag == t) begin
            e_hit  = 1'b1;
            e_data = q[i].data;
          end
        end
      end
      check($sformatf("model_lk_hit%0d", p), lk_hit[p], e_hit);
      check($sformatf("model_lk_data%0d", p), lk_data[p*16 +: 16], e_data);
    end
  end

  // Drive one cycle of lanes, then sample 1 time unit after the edge that consumed them.
  task automatic cycle_in(input logic [3:0] v, input logic [19:0] t, input logic [63:0] d);
    in_valid = v;
    in_tag   = t;
    in_data  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle_in(4'h0, 20'h0, 64'h0);
  endtask

  initial begin
    logic [19:0] rt;
    logic [63:0] rd;
    rst_n    = 1'b1;
    in_valid = '0;
    in_data  = '0;
    in_tag   = '0;
    lk_tag   = '0;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check("reset_stall", stall, 1'b0);
    check("reset_wr_en", wr_en, 2'b00);
    check("reset_lk_hit", lk_hit, 9'h0);

    // Single lane result appears on port 0 the cycle after acceptance.
    cycle_in(4'b0001, {15'h0, 5'd3}, {48'h0, 16'h00AA});
    check("single_wr_en", wr_en, 2'b01);
    check("single_wr_tag", wr_tag[4:0], 5'd3);
    check("single_wr_data", wr_data[15:0], 16'h00AA);
    idle(1);
    check("single_after_wr_en", wr_en, 2'b00);

    // Tag-0 lane and an invalid lane are dropped; 7 and 9 are compacted.
    cycle_in(4'b1101, {5'd9, 5'd7, 5'd0, 5'd0}, {16'h0909, 16'h0707, 16'h0505, 16'h0303});
    check("gap_wr_en", wr_en, 2'b11);
    check("gap_wr_tag0", wr_tag[4:0], 5'd7);
    check("gap_wr_tag1", wr_tag[9:5], 5'd9);
    idle(1);

    // Same-tag collapse with forwarding of the younger value.
    lk_tag = {9{5'd5}};
    cycle_in(4'b0011, {5'd0, 5'd0, 5'd5, 5'd5}, {32'h0, 16'h2222, 16'h1111});
    check("collapse_wr_en", wr_en, 2'b10);
    check("collapse_wr_data1", wr_data[31:16], 16'h2222);
    check("collapse_lk_hit", lk_hit[0], 1'b1);
    check("collapse_lk_data", lk_data[15:0], 16'h2222);
    idle(1);
    check("collapse_after_lk_hit", lk_hit, 9'h0);
    lk_tag = '0;

    // Full-width bursts: stall rises at count 6 and incoming lanes are ignored while high.
    for (int c = 0; c < 4; c++) begin
      cycle_in(4'hF, {5'd4, 5'd3, 5'd2, 5'd1},
               {8'(c), 8'h4, 8'(c), 8'h3, 8'(c), 8'h2, 8'(c), 8'h1});
      case (c)
        0: begin
          check("burst0_stall", stall, 1'b0);
          check("burst0_wr_tag", wr_tag, {5'd2, 5'd1});
        end
        1: begin
          check("burst1_stall", stall, 1'b1);
          check("burst1_wr_tag", wr_tag, {5'd4, 5'd3});
        end
        2: begin
          check("burst2_stall", stall, 1'b0);
          check("burst2_wr_tag", wr_tag, {5'd2, 5'd1});
        end
        default: begin
          check("burst3_stall", stall, 1'b1);
          check("burst3_wr_data0", wr_data[15:0], 16'h0103);
        end
      endcase
    end
    idle(5);
    check("burst_drained_wr_en", wr_en, 2'b00);

    // Asynchronous reset with five entries buffered.
    lk_tag = {40'h0, 5'd3};
    cycle_in(4'hF, {5'd4, 5'd3, 5'd2, 5'd1}, {16'hA004, 16'hA003, 16'hA002, 16'hA001});
    cycle_in(4'b0111, {5'd0, 5'd3, 5'd2, 5'd1}, {16'h0, 16'hB003, 16'hB002, 16'hB001});
    check("pre_reset_stall", stall, 1'b1);
    check("pre_reset_lk_hit", lk_hit[0], 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("midreset_wr_en", wr_en, 2'b00);
    check("midreset_stall", stall, 1'b0);
    check("midreset_lk_hit", lk_hit, 9'h0);
    @(posedge clk);
    #1;
    check("reset_cycle_wr_en", wr_en, 2'b00);
    in_valid = '0;
    rst_n    = 1'b1;
    idle(3);
    check("post_reset_wr_en", wr_en, 2'b00);
    lk_tag = '0;

    // Random lane masks, tags and lookups across several pointer wraps.
    for (int c = 0; c < 60; c++) begin
      for (int i = 0; i < 4; i++) begin
        rt[i*5 +: 5]  = 5'($urandom_range(0, 31));
        rd[i*16 +: 16] = 16'($urandom);
      end
      for (int p = 0; p < 9; p++) lk_tag[p*5 +: 5] = 5'($urandom_range(0, 31));
      cycle_in(4'($urandom_range(0, 15)), rt, rd);
    end
    lk_tag = '0;
    idle(8);
    check("final_wr_en", wr_en, 2'b00);
    check("final_stall", stall, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
